kf8255_mode1_peer: RTL and testbench

//  Peripheral-side partner for one KF8255 port running Mode 1 (strobed I/O).
//  - 8255 port = output: peer takes bytes via OBF#/ACK#.
//  - 8255 port = input: peer sends bytes via STB#/IBF.

---
 rtl/kf8255_peer_pkg.sv | 11 +
 rtl/kf8255_peer_fifo.sv | 51 +++++
 rtl/kf8255_mode1_peer.sv | 176 +++++++++++++++++
 tb/tb_kf8255_mode1_peer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/kf8255_peer_pkg.sv
// Shared types and constants for the KF8255 Mode 1 peripheral-side peer.
package kf8255_peer_pkg;

    typedef enum logic [1:0] {RX_IDLE, RX_LATCH, RX_ACK, RX_WAIT} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_SETUP, TX_STROBE, TX_HOLD} tx_state_t;

    localparam logic [1:0] MODE_STROBED = 2'b01;
    localparam logic       PORT_DIR_OUT = 1'b0;
    localparam logic       PORT_DIR_IN  = 1'b1;

endpackage

// File: rtl/kf8255_peer_fifo.sv
// Synchronous byte FIFO buffering bytes received from the 8255 port.
// Push while full and pop while empty are ignored.
module kf8255_peer_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = empty ? '0 : mem[rd_ptr_q];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/kf8255_mode1_peer.sv
// Peripheral-side partner for one KF8255 port in Mode 1 (OBF#/ACK# receive, STB#/IBF send).
// Optional TX wait timeout enabled with `define KF8255_PEER_TIMEOUT_EN.
module kf8255_mode1_peer
    import kf8255_peer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned ACK_WIDTH      = 2,
    parameter int unsigned STB_WIDTH      = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] mode_select,
    input  logic       port_io,
    input  logic [7:0] port_data_in,
    output logic [7:0] port_data_out,
    output logic       port_data_oe,
    input  logic       obf_n,
    output logic       ack_n,
    output logic       stb_n,
    input  logic       ibf,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       timeout
);

    localparam int unsigned AckCntW = (ACK_WIDTH > 1) ? $clog2(ACK_WIDTH) : 1;
    localparam int unsigned StbCntW = (STB_WIDTH > 1) ? $clog2(STB_WIDTH) : 1;
    localparam logic [AckCntW-1:0] AckLast = AckCntW'(ACK_WIDTH - 1);
    localparam logic [StbCntW-1:0] StbLast = StbCntW'(STB_WIDTH - 1);

    rx_state_t rx_state_q, rx_state_d;
    tx_state_t tx_state_q, tx_state_d;
    logic [AckCntW-1:0] ack_cnt_q, ack_cnt_d;
    logic [StbCntW-1:0] stb_cnt_q, stb_cnt_d;
    logic [7:0] tx_byte_q, tx_byte_d;
    logic rx_run, tx_run, push, fifo_full, fifo_empty, tx_accept, tx_drop;

    assign rx_run = (mode_select == MODE_STROBED) & (port_io == PORT_DIR_OUT);
    assign tx_run = (mode_select == MODE_STROBED) & (port_io == PORT_DIR_IN);

    kf8255_peer_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (port_data_in),
        .pop       (rx_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (rx_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_state_q <= RX_IDLE;
            tx_state_q <= TX_IDLE;
            ack_cnt_q  <= '0;
            stb_cnt_q  <= '0;
            tx_byte_q  <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            tx_state_q <= tx_state_d;
            ack_cnt_q  <= ack_cnt_d;
            stb_cnt_q  <= stb_cnt_d;
            tx_byte_q  <= tx_byte_d;
        end
    end

    // Leaving the active mode/direction aborts whatever is in flight.
    always_comb begin
        rx_state_d = rx_state_q;
        ack_cnt_d  = ack_cnt_q;
        push       = 1'b0;
        if (!rx_run) begin
            rx_state_d = RX_IDLE;
            ack_cnt_d  = '0;
        end else begin
            case (rx_state_q)
                RX_IDLE:  if (!obf_n && !fifo_full) rx_state_d = RX_LATCH;
                RX_LATCH: begin
                    push       = 1'b1;
                    ack_cnt_d  = '0;
                    rx_state_d = RX_ACK;
                end
                RX_ACK: begin
                    if (ack_cnt_q == AckLast) begin
                        ack_cnt_d  = '0;
                        rx_state_d = RX_WAIT;
                    end else begin
                        ack_cnt_d = ack_cnt_q + AckCntW'(1);
                    end
                end
                RX_WAIT:  if (obf_n) rx_state_d = RX_IDLE;
                default:  rx_state_d = RX_IDLE;
            endcase
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        stb_cnt_d  = stb_cnt_q;
        tx_byte_d  = tx_byte_q;
        tx_accept  = 1'b0;
        if (!tx_run) begin
            tx_state_d = TX_IDLE;
            stb_cnt_d  = '0;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (tx_valid && !ibf) begin
                        tx_accept  = 1'b1;
                        tx_byte_d  = tx_data;
                        tx_state_d = TX_SETUP;
                    end
                end
                TX_SETUP: begin
                    stb_cnt_d  = '0;
                    tx_state_d = TX_STROBE;
                end
                TX_STROBE: begin
                    if (stb_cnt_q == StbLast) begin
                        stb_cnt_d  = '0;
                        tx_state_d = TX_HOLD;
                    end else begin
                        stb_cnt_d = stb_cnt_q + StbCntW'(1);
                    end
                end
                TX_HOLD:  tx_state_d = TX_IDLE;
                default:  tx_state_d = TX_IDLE;
            endcase
        end
    end

`ifdef KF8255_PEER_TIMEOUT_EN
    localparam int unsigned ToCntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [ToCntW-1:0] ToLast = ToCntW'(TIMEOUT_CYCLES - 1);
    logic [ToCntW-1:0] to_cnt_q, to_cnt_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) to_cnt_q <= '0;
        else       to_cnt_q <= to_cnt_d;
    end

    // Counter clears whenever the blocked-send condition lapses.
    always_comb begin
        to_cnt_d = '0;
        tx_drop  = 1'b0;
        if (tx_run && tx_state_q == TX_IDLE && tx_valid && ibf) begin
            if (to_cnt_q == ToLast) tx_drop = 1'b1;
            else                    to_cnt_d = to_cnt_q + ToCntW'(1);
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign tx_drop = 1'b0;
`endif

    assign timeout       = tx_drop;
    assign tx_ready      = tx_accept | tx_drop;
    assign ack_n         = (rx_state_q != RX_ACK);
    assign stb_n         = (tx_state_q != TX_STROBE);
    assign port_data_oe  = (tx_state_q != TX_IDLE);
    assign port_data_out = tx_byte_q;
    assign rx_valid      = ~fifo_empty;
    assign busy          = (rx_state_q != RX_IDLE) | (tx_state_q != TX_IDLE);

endmodule

// File: tb/tb_kf8255_mode1_peer.sv
// Directed self-checking bench for kf8255_mode1_peer (default and KF8255_PEER_TIMEOUT_EN builds).
module tb_kf8255_mode1_peer;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] mode_select;
    logic       port_io;
    logic [7:0] port_data_in;
    logic [7:0] port_data_out;
    logic       port_data_oe;
    logic       obf_n;
    logic       ack_n;
    logic       stb_n;
    logic       ibf;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       timeout;

    int n_tests = 0;
    int n_fail  = 0;

    kf8255_mode1_peer #(
        .FIFO_DEPTH     (4),
        .ACK_WIDTH      (2),
        .STB_WIDTH      (2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .mode_select   (mode_select),
        .port_io       (port_io),
        .port_data_in  (port_data_in),
        .port_data_out (port_data_out),
        .port_data_oe  (port_data_oe),
        .obf_n         (obf_n),
        .ack_n         (ack_n),
        .stb_n         (stb_n),
        .ibf           (ibf),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .busy          (busy),
        .timeout       (timeout)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One complete OBF#/ACK# exchange; reports whether ACK# was seen in time.
    task automatic rx_xfer(input logic [7:0] b, output bit ok);
        ok = 1'b0;
        port_data_in = b;
        obf_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!ack_n) begin
                ok = 1'b1;
                break;
            end
        end
        obf_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!busy) break;
            tick();
        end
    endtask

    initial begin
        bit ok;
        int lows, first_to, n_to, stb_lows;
        logic [7:0] exp_q [4];

        reset = 1'b1; mode_select = 2'b01; port_io = 1'b0; port_data_in = 8'h00;
        obf_n = 1'b1; ibf = 1'b0; rx_ready = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
        tick(); tick();
        check("rst_ack_n", ack_n, 1'b1);
        check("rst_stb_n", stb_n, 1'b1);
        check("rst_oe", port_data_oe, 1'b0);
        check("rst_dout", port_data_out, 8'h00);
        check("rst_tx_ready", tx_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        reset = 1'b0;
        tick();

        // Basic receive with exact ACK# timing
        port_data_in = 8'hA5;
        obf_n = 1'b0;
        tick();
        check("rx_latch_ack_n", ack_n, 1'b1);
        check("rx_latch_busy", busy, 1'b1);
        tick();
        check("rx_ack1_ack_n", ack_n, 1'b0);
        check("rx_valid", rx_valid, 1'b1);
        check("rx_data", rx_data, 8'hA5);
        tick();
        check("rx_ack2_ack_n", ack_n, 1'b0);
        obf_n = 1'b1;
        tick();
        check("rx_after_ack_n", ack_n, 1'b1);
        tick();
        check("rx_idle_busy", busy, 1'b0);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check("rx_pop_empty", rx_valid, 1'b0);

        // Asynchronous reset in the middle of ACK#
        port_data_in = 8'h77;
        obf_n = 1'b0;
        tick(); tick();
        check("mid_ack_low", ack_n, 1'b0);
        reset = 1'b1;
        #1;
        check("async_rst_ack_n", ack_n, 1'b1);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_rx_valid", rx_valid, 1'b0);
        obf_n = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // Fill the FIFO, then back-pressure the fifth byte
        exp_q[0] = 8'h22; exp_q[1] = 8'h33; exp_q[2] = 8'h44; exp_q[3] = 8'h55;
        rx_xfer(8'h11, ok); check("fill0_acked", ok, 1'b1);
        rx_xfer(8'h22, ok); check("fill1_acked", ok, 1'b1);
        rx_xfer(8'h33, ok); check("fill2_acked", ok, 1'b1);
        rx_xfer(8'h44, ok); check("fill3_acked", ok, 1'b1);
        port_data_in = 8'h55;
        obf_n = 1'b0;
        lows = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (!ack_n) lows++;
        end
        check("full_no_ack", lows, 0);
        check("full_idle", busy, 1'b0);
        check("full_head", rx_data, 8'h11);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!ack_n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("after_pop_acked", ok, 1'b1);
        obf_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!busy) break;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d", i), rx_data, exp_q[i]);
            rx_ready = 1'b1;
            tick();
            rx_ready = 1'b0;
        end
        check("drain_empty", rx_valid, 1'b0);

        // Basic send
        port_io = 1'b1;
        tick();
        tx_data = 8'h3C;
        tx_valid = 1'b1;
        #1;
        check("tx_accept", tx_ready, 1'b1);
        tick();
        tx_valid = 1'b0;
        tx_data = 8'hFF;
        #1;
        check("tx_ready_drop", tx_ready, 1'b0);
        check("setup_oe", port_data_oe, 1'b1);
        check("setup_stb_n", stb_n, 1'b1);
        check("setup_data", port_data_out, 8'h3C);
        tick();
        check("stb1_stb_n", stb_n, 1'b0);
        check("stb1_data", port_data_out, 8'h3C);
        tick();
        check("stb2_stb_n", stb_n, 1'b0);
        tick();
        check("hold_stb_n", stb_n, 1'b1);
        check("hold_oe", port_data_oe, 1'b1);
        check("hold_data", port_data_out, 8'h3C);
        tick();
        check("tx_done_oe", port_data_oe, 1'b0);
        check("tx_done_busy", busy, 1'b0);

        // Mode change during STROBE aborts the send
        tx_data = 8'h5A;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tick();
        check("abort_in_strobe", stb_n, 1'b0);
        mode_select = 2'b00;
        tick();
        check("abort_stb_n", stb_n, 1'b1);
        check("abort_oe", port_data_oe, 1'b0);
        check("abort_busy", busy, 1'b0);
        mode_select = 2'b01;
        tick();

        // IBF held high: no strobe; timeout pulse only in the timeout build
        ibf = 1'b1;
        tx_data = 8'hC3;
        tx_valid = 1'b1;
        first_to = 0;
        n_to = 0;
        stb_lows = 0;
        for (int i = 1; i <= 12; i++) begin
            #1;
            if (timeout) begin
                n_to++;
                if (first_to == 0) first_to = i;
                check("to_tx_ready", tx_ready, 1'b1);
            end
            if (!stb_n) stb_lows++;
            tick();
        end
        check("ibf_no_strobe", stb_lows, 0);
        check("ibf_idle", busy, 1'b0);
`ifdef KF8255_PEER_TIMEOUT_EN
        check("timeout_cycle", first_to, 8);
        check("timeout_count", n_to, 1);
`else
        check("timeout_cycle", first_to, 0);
        check("timeout_count", n_to, 0);
`endif
        ibf = 1'b0;
        #1;
        check("ibf_clear_accept", tx_ready, 1'b1);
        tick();
        tx_valid = 1'b0;
        check("ibf_clear_data", port_data_out, 8'hC3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
